// File: rtl/ifu_spill_pkg.sv
// Shared fetch-unit configuration and the halfword-spill state encoding.
package ifu_spill_pkg;

  // Core configuration: datapath width, reset PC, compressed-ISA support.
  localparam int                    CFG_XLEN          = 64;
  localparam logic [CFG_XLEN-1:0]   CFG_RESET_VECTOR  = 64'h0000_0000_8000_0000;
  localparam bit                    CFG_ZCA_SUPPORTED = 1'b1;

  // READY: one ROM read delivers a whole instruction.
  // SPILL: the low half is parked, waiting for the upper half from PC+2.
  typedef enum logic {
    READY = 1'b0,
    SPILL = 1'b1
  } spill_state_e;

endpackage

// File: rtl/ifu_spill_flopenr.sv
// Enabled flop with synchronous active-high reset to a fixed value.
module ifu_spill_flopenr #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset wins over enable; otherwise load d only when enabled.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of process evaluation order.
    if (reset)   q <= RESET_VALUE;
    else if (en) q <= d;
  end

endmodule

// File: rtl/ifu_spill.sv
// Fetch PC register plus halfword-spill sequencer. A 32-bit instruction that
// starts on a halfword boundary is fetched in two ROM reads; the first half is
// parked and a merged instruction is presented with the original PC.
module ifu_spill
  import ifu_spill_pkg::*;
#(
  parameter int              XLEN          = CFG_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR  = CFG_RESET_VECTOR,
  parameter bit              ZCA_SUPPORTED = CFG_ZCA_SUPPORTED
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallF,
  input  logic            FlushF,
  input  logic [XLEN-1:0] PCNextF,
  input  logic [31:0]     IROMInstrF,
  output logic [XLEN-1:0] PCSpillNextF,
  output logic            IROMce,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCSpillF,
  output logic [31:0]     InstrF,
  output logic            CompressedF,
  output logic            SpillStallF
);

  spill_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_plus2;
  logic            zca_en;
  logic            spill_det;
  logic            capture;
  logic [15:0]     half_q;
  logic [XLEN-1:0] saved_pc_q;

  // The ROM is only enabled when fetch advances; a stalled ROM keeps its data.
  assign IROMce   = ~StallF;
  assign pc_plus2 = PCF + XLEN'(2);
  assign zca_en   = ZCA_SUPPORTED;

  // A spill is a non-compressed instruction starting at PC[1]=1. A flush
  // suppresses detection so the redirect target goes straight to the ROM.
  assign spill_det = zca_en & PCF[1] & (IROMInstrF[1:0] == 2'b11) & ~FlushF;

  // Park the first half only when fetch actually advances to PC+2.
  assign capture = (state_q == READY) & spill_det & ~StallF;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= READY;
    else       state_q <= state_d;
  end

  // Next-state: enter SPILL on a captured spill, leave once fetch advances.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      READY: if (capture) state_d = SPILL;
      SPILL: if (~StallF) state_d = READY;
    endcase
  end

  // Outputs: ROM address, merged instruction and its PC, hazard request.
  always_comb begin
    // NOTE: every output gets a default before the case so no path through
    // this block can leave a value unassigned and infer a latch.
    PCSpillNextF = PCNextF;
    SpillStallF  = 1'b0;
    InstrF       = IROMInstrF;
    PCSpillF     = PCF;
    unique case (state_q)
      READY: begin
        PCSpillNextF = spill_det ? pc_plus2 : PCNextF;
        SpillStallF  = spill_det;
      end
      SPILL: begin
        InstrF   = {IROMInstrF[15:0], half_q};
        PCSpillF = saved_pc_q;
      end
    endcase
  end

  assign CompressedF = (InstrF[1:0] != 2'b11);

  // Fetch PC: follows the ROM address whenever fetch is not stalled.
  ifu_spill_flopenr #(.WIDTH(XLEN), .RESET_VALUE(RESET_VECTOR)) u_pcf (
    .clk   (clk),
    .reset (reset),
    .en    (~StallF),
    .d     (PCSpillNextF),
    .q     (PCF)
  );

  // First half of a spilled instruction.
  ifu_spill_flopenr #(.WIDTH(16), .RESET_VALUE(16'h0)) u_half (
    .clk   (clk),
    .reset (reset),
    .en    (capture),
    .d     (IROMInstrF[15:0]),
    .q     (half_q)
  );

  // PC of the spilled instruction, reported while the upper half arrives.
  ifu_spill_flopenr #(.WIDTH(XLEN), .RESET_VALUE(RESET_VECTOR)) u_saved_pc (
    .clk   (clk),
    .reset (reset),
    .en    (capture),
    .d     (PCF),
    .q     (saved_pc_q)
  );

endmodule
